// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch / load-store) for the byte-wide memory port.
// Each grant becomes a little-endian byte sequence on the bus.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_SEL_HI  = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  ls_req,
  input  logic                  ls_wr,
  input  logic [1:0]            ls_size,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, RET} state_t;

  state_t                st, st_d;
  logic [2:0]            cnt, cnt_d;     // byte index currently on the bus
  logic [2:0]            nb, nb_d;       // byte count of the transfer
  logic [2:0]            cn;
  logic [1:0]            bi;
  logic [ADDR_WIDTH-1:0] base, base_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [ADDR_WIDTH-1:0] a_prev;         // bus address of the last active cycle
  logic [7:0]            dout_q, dout_d;
  logic                  wr_q, wr_d;
  logic [31:0]           data_q, data_d;
  logic                  own_if, own_if_d;
  logic                  lg_if, lg_if_d; // last grant went to fetch
  logic                  is_io, stall, if_ok, gnt_ls, gnt_if;

  assign is_io  = (a_q[IO_SEL_HI -: 2] == 2'b11);
  assign stall  = (st == LS_WR) && is_io && io_buffer_full;
  assign if_ok  = if_req && !flush;
  assign gnt_ls = ls_req && (!if_ok || lg_if);
  assign gnt_if = if_ok && !gnt_ls;
  assign cn     = cnt + 3'd1;
  assign bi     = cnt[1:0] - 2'd1;

  // Next-state and datapath: arbitration, byte sequencing, read assembly
  always_comb begin
    st_d     = st;
    cnt_d    = cnt;
    nb_d     = nb;
    base_d   = base;
    a_d      = a_q;
    dout_d   = dout_q;
    wr_d     = wr_q;
    data_d   = data_q;
    own_if_d = own_if;
    lg_if_d  = lg_if;
    case (st)
      IDLE: begin
        if (gnt_ls || gnt_if) begin
          base_d   = gnt_ls ? ls_addr : if_addr;
          a_d      = gnt_ls ? ls_addr : if_addr;
          cnt_d    = 3'd0;
          data_d   = 32'd0;
          own_if_d = gnt_if;
          lg_if_d  = gnt_if;
          if (gnt_if) begin
            nb_d = 3'd4;
            st_d = IF_RD;
          end else begin
            case (ls_size)
              2'b00:   nb_d = 3'd1;
              2'b01:   nb_d = 3'd2;
              default: nb_d = 3'd4;
            endcase
            if (ls_wr) begin
              st_d   = LS_WR;
              wr_d   = 1'b1;
              dout_d = ls_wdata[7:0];
            end else begin
              st_d = LS_RD;
            end
          end
        end
      end
      IF_RD, LS_RD: begin
        if (st == IF_RD && flush) begin
          st_d  = IDLE;
          a_d   = '0;
          cnt_d = 3'd0;
        end else begin
          // mem_din carries the byte addressed one cycle earlier
          if (cnt != 3'd0) data_d[{bi, 3'b000} +: 8] = mem_din;
          if (cnt == nb) begin
            st_d = RET;
            a_d  = '0;
          end else begin
            cnt_d = cn;
            a_d   = (cn == nb) ? '0 : base + {{(ADDR_WIDTH-3){1'b0}}, cn};
          end
        end
      end
      LS_WR: begin
        if (!stall) begin
          if (cn == nb) begin
            st_d   = RET;
            a_d    = '0;
            dout_d = 8'd0;
            wr_d   = 1'b0;
          end else begin
            cnt_d  = cn;
            a_d    = base + {{(ADDR_WIDTH-3){1'b0}}, cn};
            dout_d = ls_wdata[{cn[1:0], 3'b000} +: 8];
          end
        end
      end
      RET: begin
        st_d  = IDLE;
        cnt_d = 3'd0;
      end
      default: st_d = IDLE;
    endcase
  end

  // State register; rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      cnt    <= 3'd0;
      nb     <= 3'd0;
      base   <= '0;
      a_q    <= '0;
      a_prev <= '0;
      dout_q <= 8'd0;
      wr_q   <= 1'b0;
      data_q <= 32'd0;
      own_if <= 1'b0;
      lg_if  <= 1'b1;
    end else if (rdy) begin
      st     <= st_d;
      cnt    <= cnt_d;
      nb     <= nb_d;
      base   <= base_d;
      a_q    <= a_d;
      a_prev <= a_q;
      dout_q <= dout_d;
      wr_q   <= wr_d;
      data_q <= data_d;
      own_if <= own_if_d;
      lg_if  <= lg_if_d;
    end
  end

  // While frozen, keep showing the last active address so that mem_din
  // still returns the byte still owed to the assembly register on resume.
  assign mem_a    = rdy ? a_q : a_prev;
  assign mem_dout = dout_q;
  assign mem_wr   = wr_q && rdy && !stall;
  assign if_done  = rdy && (st == RET) && own_if && !flush;
  assign ls_done  = rdy && (st == RET) && !own_if;
  assign if_data  = data_q;
  assign ls_rdata = data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model (one-cycle read latency).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_wr, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  int total = 0;
  int bad   = 0;

  logic [7:0] ram [logic [31:0]];

  mem_arbiter #(.ADDR_WIDTH(32), .IO_SEL_HI(17)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM model: write on strobe, read data appears the following cycle
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'b00; ls_addr = '0; ls_wdata = '0;
    io_buffer_full = 1'b0;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h2000] = 8'h78; ram[32'h2001] = 8'h56; ram[32'h2002] = 8'h34; ram[32'h2003] = 8'h12;
    tick; tick;
    chk("rst_a", mem_a, 32'h0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_dout", mem_dout, 0);
    chk("rst_ifd", if_done, 0);
    chk("rst_lsd", ls_done, 0);
    rst = 1'b0;
    tick;

    // fetch word at 0x1000
    if_req = 1'b1; if_addr = 32'h1000;
    for (int c = 1; c <= 6; c++) begin
      tick;
      if (c <= 4) chk("t1_a", mem_a, 32'h1000 + c - 1);
      chk("t1_wr", mem_wr, 0);
      chk("t1_ifd", if_done, (c == 6));
      if (c == 6) begin
        chk("t1_data", if_data, 32'h0000_0513);
        if_req = 1'b0;
      end
    end
    tick;

    // tie after reset goes to LS, then IF, then LS again
    if_req = 1'b1; if_addr = 32'h1000;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b10; ls_addr = 32'h2000;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (c == 1)  chk("t2_ls_first", mem_a, 32'h2000);
      if (c == 6)  begin chk("t2_lsd", ls_done, 1); chk("t2_rdata", ls_rdata, 32'h1234_5678); ls_req = 1'b0; end
      if (c == 7)  chk("t2_idle_a", mem_a, 32'h0);
      if (c == 8)  chk("t2_if_next", mem_a, 32'h1000);
      if (c == 12) chk("t2_ifd_early", if_done, 0);
      if (c == 13) begin chk("t2_ifd", if_done, 1); chk("t2_ifdata", if_data, 32'h0000_0513); ls_req = 1'b1; end
      if (c == 15) chk("t2_tie_ls", mem_a, 32'h2000);
      if (c == 20) begin chk("t2_lsd2", ls_done, 1); ls_req = 1'b0; if_req = 1'b0; end
    end
    tick;

    // store half 0xBEEF to 0x2002, then load byte 0x2003
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b01; ls_addr = 32'h2002; ls_wdata = 32'h0000_BEEF;
    tick;
    chk("t3_a1", mem_a, 32'h2002); chk("t3_d1", mem_dout, 8'hEF); chk("t3_w1", mem_wr, 1);
    tick;
    chk("t3_a2", mem_a, 32'h2003); chk("t3_d2", mem_dout, 8'hBE); chk("t3_w2", mem_wr, 1);
    tick;
    chk("t3_lsd", ls_done, 1); chk("t3_w3", mem_wr, 0);
    ls_req = 1'b0;
    tick;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b00; ls_addr = 32'h2003;
    tick; tick;
    chk("t3_lsd_early", ls_done, 0);
    tick;
    chk("t3_lsd_ld", ls_done, 1); chk("t3_rdata", ls_rdata, 32'h0000_00BE);
    ls_req = 1'b0;
    tick;

    // IO store stalled by full UART buffer
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b00; ls_addr = 32'h0003_0000; ls_wdata = 32'h41;
    for (int c = 1; c <= 3; c++) begin
      tick;
      io_buffer_full = 1'b1;
      #1;
      chk("t4_stall_wr", mem_wr, 0);
      chk("t4_stall_a", mem_a, 32'h0003_0000);
    end
    tick;
    io_buffer_full = 1'b0;
    #1;
    chk("t4_wr", mem_wr, 1); chk("t4_dout", mem_dout, 8'h41);
    tick;
    chk("t4_lsd", ls_done, 1);
    chk("t4_ram", ram[32'h0003_0000], 8'h41);
    ls_req = 1'b0;
    tick;

    // flush aborts fetch; pending LS proceeds
    if_req = 1'b1; if_addr = 32'h1000;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b10; ls_addr = 32'h2000;
    for (int c = 1; c <= 9; c++) begin
      tick;
      if (c == 2) begin flush = 1'b1; if_req = 1'b0; #1; end
      if (c == 3) flush = 1'b0;
      chk("t5_no_ifd", if_done, 0);
      if (c == 1) chk("t5_if_won", mem_a, 32'h1000);
      if (c == 3) chk("t5_idle_a", mem_a, 32'h0);
      if (c == 4) chk("t5_ls_a", mem_a, 32'h2000);
      if (c == 9) begin chk("t5_lsd", ls_done, 1); chk("t5_rdata", ls_rdata, 32'hBEEF_5678); ls_req = 1'b0; end
    end
    tick;

    // rdy low for 5 cycles during a word load
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b10; ls_addr = 32'h2000;
    tick; chk("t6_a1", mem_a, 32'h2000);
    tick; chk("t6_a2", mem_a, 32'h2001);
    for (int c = 3; c <= 7; c++) begin
      tick;
      rdy = 1'b0;
      #1;
      chk("t6_frz_a", mem_a, 32'h2001);
      chk("t6_frz_wr", mem_wr, 0);
      chk("t6_frz_lsd", ls_done, 0);
    end
    tick;
    rdy = 1'b1;
    #1;
    chk("t6_resume_a", mem_a, 32'h2002);
    tick; tick;
    chk("t6_lsd_early", ls_done, 0);
    tick;
    chk("t6_lsd", ls_done, 1); chk("t6_rdata", ls_rdata, 32'hBEEF_5678);
    ls_req = 1'b0;
    tick;

    // reset in the middle of a word store
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b10; ls_addr = 32'h2100; ls_wdata = 32'h1122_3344;
    tick;
    chk("t7_w1", mem_wr, 1); chk("t7_a1", mem_a, 32'h2100); chk("t7_d1", mem_dout, 8'h44);
    tick;
    rst = 1'b1; ls_req = 1'b0;
    tick;
    rst = 1'b0;
    #1;
    chk("t7_rst_wr", mem_wr, 0); chk("t7_rst_a", mem_a, 32'h0); chk("t7_rst_lsd", ls_done, 0);
    for (int c = 4; c <= 5; c++) begin
      tick;
      chk("t7_no_lsd", ls_done, 0);
      chk("t7_no_wr", mem_wr, 0);
    end
    chk("t7_ram0", ram[32'h2100], 8'h44);
    chk("t7_ram2", ram.exists(32'h2102), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM/IO port of riscv_top between two requesters: instruction fetch (IF) and the load/store unit (LS).
- Each granted request becomes a byte-serial, little-endian sequence on the memory bus. The assembled word or a completion pulse is returned to the requester.
- Sits inside the CPU, between the fetch/LS units and the top-level mem_din/mem_dout/mem_a/mem_wr/io_buffer_full pins.

Parameters:
ADDR_WIDTH, 32, width of all address ports
IO_SEL_HI, 17, upper bit of IO region decode; IO when addr[IO_SEL_HI:IO_SEL_HI-1]==2'b11

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; 0 freezes block
flush  in  1  branch mispredict; aborts an in-flight or pending IF request
if_req  in  1  fetch request; held with if_addr until if_done or flush
if_addr  in  ADDR_WIDTH  fetch address; always 4 bytes
if_done  out  1  one-cycle pulse; if_data valid
if_data  out  32  fetched word
ls_req  in  1  load/store request; held stable until ls_done
ls_wr  in  1  1=store, 0=load
ls_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
ls_addr  in  ADDR_WIDTH  data address
ls_wdata  in  32  store data; low bytes used
ls_done  out  1  one-cycle pulse; ls_rdata valid for loads
ls_rdata  out  32  load data, zero-extended
mem_din  in  8  RAM read byte; reflects the address of the previous cycle
mem_dout  out  8  write byte
mem_a  out  ADDR_WIDTH  byte address
mem_wr  out  1  write strobe
io_buffer_full  in  1  UART buffer full; IO writes must not issue while high

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant=IF, so the first tie goes to LS.
- rdy=0: all registers hold, mem_wr forced 0, no done pulses. Operation resumes unchanged when rdy=1.
- States: IDLE, IF_RD, LS_RD, LS_WR, RET.
- IDLE, arbitration:
  - Only one request valid: grant it.
  - Both valid: grant the requester not in last_grant (round-robin). Update last_grant on every grant.
  - IF is not granted in a cycle where flush=1.
- Counting: N = byte count (IF 4; LS 1/2/4). Cycle 0 is the cycle the request is sampled in IDLE.
- Reads (IF_RD/LS_RD):
  - Cycle k (1..N): mem_a=addr+k, where k runs 0..N-1 over cycles 1..N; mem_wr=0.
  - Byte k is captured from mem_din in cycle k+1 into bits [8k+7:8k]. Upper bytes are cleared at grant.
  - After capture, go to RET. The done pulse plus data are asserted in cycle N+2.
- Writes (LS_WR):
  - Cycles 1..N: mem_a=addr+k, mem_dout=ls_wdata[8k+7:8k], mem_wr=1.
  - ls_done is pulsed in cycle N+1.
- IO stall: if the current write byte address decodes to IO and io_buffer_full=1, that cycle has mem_wr=0, mem_a held, and the counter holds. Completion slips one cycle per stalled cycle. Reads are never stalled.
- RET: the done pulse cycle. FSM returns to IDLE next cycle; the earliest new grant is sampled one cycle after RET.
- mem_a=0 and mem_dout=0 whenever idle. mem_wr is never 1 outside LS_WR.
- flush:
  - In IF_RD or RET-for-IF: abort, no if_done, IDLE next cycle.
  - LS transfers are unaffected by flush; stores always complete.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- rst mid-transfer: mem_wr=0 and IDLE on the next cycle; the partial transfer is discarded.

Test Plan:
- RAM[0x1000..0x1003]=13 05 00 00; if_req, if_addr=0x1000 at cycle 0 -> mem_a 0x1000..0x1003 in cycles 1-4, mem_wr=0, if_done cycle 6, if_data=0x00000513.
- After reset, if_req and ls_req (load word 0x2000) both asserted -> LS granted first; IF granted the cycle after ls_done+1; a repeated tie after that goes to LS.
- Store half 0xBEEF to 0x2002 -> cycle 1: mem_a=0x2002, mem_dout=0xEF, mem_wr=1; cycle 2: mem_a=0x2003, mem_dout=0xBE; ls_done cycle 3. Load byte 0x2003 returns 0x000000BE.
- Store byte 0x41 to 0x30000 with io_buffer_full=1 for cycles 1-3 -> mem_wr=0 in cycles 1-3, mem_wr=1 in cycle 4, ls_done cycle 5.
- flush at cycle 2 of IF_RD with ls_req pending -> no if_done ever; LS granted from IDLE and completes normally.
- rdy=0 for 5 cycles during a word load -> mem_a frozen, mem_wr=0; ls_rdata correct and ls_done 5 cycles late. rst during a word store -> mem_wr=0 on the next cycle, no ls_done.
